// File: rtl/piece_pkg.sv
// Shared constants for the piece move scheduler: PS/2 scan codes, the move
// encoding carried through the move FIFO, FSM states and default geometry.
package piece_pkg;

    // PS/2 set-2 scan codes of interest
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Default gravity period, step size, legal top-left bounds and spawn point
    localparam int DEF_GRAV_FRAMES = 30;
    localparam int DEF_BLOCKSIZE   = 16;
    localparam int DEF_X_MIN       = 80;
    localparam int DEF_X_MAX       = 384;
    localparam int DEF_Y_MIN       = 240;
    localparam int DEF_Y_MAX       = 384;
    localparam int DEF_X_SPAWN     = 80;
    localparam int DEF_Y_SPAWN     = 320;

    typedef enum logic [1:0] {
        MV_UP    = 2'd0,
        MV_DOWN  = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GRAV = 2'd1,
        ST_KEY  = 2'd2,
        ST_LAND = 2'd3
    } state_t;

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO holding pending moves. A push while full succeeds
// when a pop happens in the same cycle; flush empties it and wins over push.
module move_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted push only
    // NOTE: the data array has no reset; pointers and count define validity, so
    // resetting the storage would only cost flops and buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/piece_move_sched.sv
// Piece move scheduler: decodes PS/2 arrow keys into a move queue and applies
// gravity and at most one queued move per frame, right after the VS falling
// edge so the piece only moves during vblank.
// Optional feature: define PIECE_MOVE_SCHED_OVF_CNT_EN to build the
// saturating overflow event counter behind o_ovf_cnt (tied to 0 otherwise).
module piece_move_sched
    import piece_pkg::*;
#(
    parameter int GRAV_FRAMES = DEF_GRAV_FRAMES,
    parameter int BLOCKSIZE   = DEF_BLOCKSIZE,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int Y_MIN       = DEF_Y_MIN,
    parameter int Y_MAX       = DEF_Y_MAX,
    parameter int X_SPAWN     = DEF_X_SPAWN,
    parameter int Y_SPAWN     = DEF_Y_SPAWN
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic [7:0] ps2_out,
    input  logic       ps2_key_pressed,
    output logic [9:0] x_squre,
    output logic [9:0] y_squre,
    output logic       o_landed,
    output logic       o_ovf,
    output logic [7:0] o_ovf_cnt
);
    // Bounds are compared in 11 bits with the step folded onto the constant
    // side (x >= MIN+STEP), so a subtraction can never wrap below zero.
    localparam logic [10:0] BS11   = 11'(BLOCKSIZE);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMIN11 = 11'(Y_MIN);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);

    state_t      state, state_nxt;
    logic        kp_q, brk, consume;
    logic [7:0]  byte_q;
    logic        push, pop, flush, full, empty, ovf_evt;
    move_t       push_move, head_move;
    logic [1:0]  head_raw;
    logic        vs_q, vs_qq, tick;
    logic [5:0]  frame_cnt;
    logic        grav_due;
    logic [10:0] x_ext, y_ext;
    logic [9:0]  x_nxt, y_nxt;

    assign consume   = kp_q && !ps2_key_pressed;
    assign grav_due  = (frame_cnt == 6'(GRAV_FRAMES - 1));
    assign x_ext     = {1'b0, x_squre};
    assign y_ext     = {1'b0, y_squre};
    assign head_move = move_t'(head_raw);
    assign ovf_evt   = push && full && !pop && !flush;

    // Byte capture and break-prefix tracking; a byte is consumed on strobe fall
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            kp_q   <= 1'b0;
            byte_q <= '0;
            brk    <= 1'b0;
        end else begin
            kp_q <= ps2_key_pressed;
            if (ps2_key_pressed) byte_q <= ps2_out;
            if (consume) begin
                if (byte_q == SC_BREAK)                brk <= 1'b1;
                else if (byte_q != SC_EXT && brk)      brk <= 1'b0;
            end
        end
    end

    // Make-code decode into a move push (E0, F0 and unknown codes are dropped)
    always_comb begin
        push      = 1'b0;
        push_move = MV_UP;
        if (consume && !brk) begin
            case (byte_q)
                SC_UP:    begin push = 1'b1; push_move = MV_UP;    end
                SC_DOWN:  begin push = 1'b1; push_move = MV_DOWN;  end
                SC_LEFT:  begin push = 1'b1; push_move = MV_LEFT;  end
                SC_RIGHT: begin push = 1'b1; push_move = MV_RIGHT; end
                default:  ;
            endcase
        end
    end

    move_fifo #(.DEPTH(4), .WIDTH(2)) u_fifo (
        .clk     (iVGA_CLK),
        .rst_n   (iRST_n),
        .flush   (flush),
        .push    (push),
        .wr_data (push_move),
        .pop     (pop),
        .rd_data (head_raw),
        .full    (full),
        .empty   (empty)
    );

    // Registered VS falling-edge detect producing a one-cycle frame tick
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            tick  <= 1'b0;
        end else begin
            vs_q  <= iVS;
            vs_qq <= vs_q;
            tick  <= vs_qq && !vs_q;
        end
    end

    // Frame counter: gravity is due on the tick where it wraps to zero
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)     frame_cnt <= '0;
        else if (tick)   frame_cnt <= grav_due ? '0 : frame_cnt + 1'b1;
    end

    // FSM state register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FSM next state, FIFO control and next position
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        x_nxt     = x_squre;
        y_nxt     = y_squre;
        case (state)
            ST_IDLE: if (tick) state_nxt = grav_due ? ST_GRAV : ST_KEY;
            ST_GRAV: begin
                if (x_ext + BS11 <= XMAX11) begin
                    x_nxt     = x_squre + 10'(BLOCKSIZE);
                    state_nxt = ST_KEY;
                end else begin
                    state_nxt = ST_LAND;
                end
            end
            ST_KEY: begin
                state_nxt = ST_IDLE;
                if (!empty) begin
                    pop = 1'b1;
                    case (head_move)
                        MV_UP:    if (x_ext >= XMIN11 + BS11) x_nxt = x_squre - 10'(BLOCKSIZE);
                        MV_DOWN:  if (x_ext + BS11 <= XMAX11) x_nxt = x_squre + 10'(BLOCKSIZE);
                        MV_LEFT:  if (y_ext >= YMIN11 + BS11) y_nxt = y_squre - 10'(BLOCKSIZE);
                        MV_RIGHT: if (y_ext + BS11 <= YMAX11) y_nxt = y_squre + 10'(BLOCKSIZE);
                        default:  ;
                    endcase
                end
            end
            ST_LAND: begin
                flush     = 1'b1;
                x_nxt     = 10'(X_SPAWN);
                y_nxt     = 10'(Y_SPAWN);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Position, landing pulse and sticky overflow flag
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_squre  <= 10'(X_SPAWN);
            y_squre  <= 10'(Y_SPAWN);
            o_landed <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            x_squre  <= x_nxt;
            y_squre  <= y_nxt;
            o_landed <= (state == ST_LAND);
            if (ovf_evt) o_ovf <= 1'b1;
        end
    end

`ifdef PIECE_MOVE_SCHED_OVF_CNT_EN
    logic [7:0] ovf_cnt;

    // Saturating count of dropped moves
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)                          ovf_cnt <= '0;
        else if (ovf_evt && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
    end

    assign o_ovf_cnt = ovf_cnt;
`else
    assign o_ovf_cnt = 8'd0;
`endif

endmodule
